stage_sequencer: RTL and testbench

//  Multicycle controller for the IF/ID/EX/MEM/WB datapath: steps one instruction through the stages per enable.

---
 rtl/stage_sequencer.sv | 155 +++++++++++++++
 tb/tb_stage_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer: walks one instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// skipping stages the opcode does not use, handshaking with data memory under a timeout, and
// counting retired instructions.
module stage_sequencer #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             mem_req,
  output logic             pc_we,
  output logic             instr_done,
  output logic             busy,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int unsigned     WaitW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpHalt = 6'h3F;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StHalt      = 3'd6,
    StError     = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             retire;

  // Next-state, retirement and sticky-flag logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_cnt_d = wait_cnt_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    retire     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        op_d = opcode;
        case (opcode)
          OpHalt:                  state_d = StHalt;
          OpR, OpLw, OpSw, OpBeq:  state_d = StExecute;
          default: begin
            state_d   = StError;
            illegal_d = 1'b1;
          end
        endcase
      end
      StExecute: begin
        case (op_q)
          OpLw, OpSw: begin
            state_d    = StMemory;
            wait_cnt_d = '0;
          end
          OpBeq:   retire  = 1'b1;
          default: state_d = StWriteback;
        endcase
      end
      StMemory: begin
        // A ready in the last allowed cycle takes priority over the timeout.
        if (mem_ready) begin
          if (op_q == OpLw) state_d = StWriteback;
          else              retire  = 1'b1;
        end else if (wait_cnt_q == WaitLast) begin
          state_d   = StError;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StWriteback: retire = 1'b1;
      default: ;  // StHalt and StError are absorbing
    endcase

    if (retire) state_d = halt_req ? StIdle : StFetch;
  end

  // Retired-instruction counter saturates rather than wrapping.
  always_comb begin
    count_d = count_q;
    if (retire && (count_q != '1)) count_d = count_q + 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      op_q       <= '0;
      wait_cnt_q <= '0;
      count_q    <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
      count_q    <= count_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

  // Moore stage enables decoded from the current state.
  always_comb begin
    if_en   = (state_q == StFetch);
    id_en   = (state_q == StDecode);
    ex_en   = (state_q == StExecute);
    mem_en  = (state_q == StMemory);
    wb_en   = (state_q == StWriteback);
    mem_req = (state_q == StMemory);
    busy    = !((state_q == StIdle) || (state_q == StHalt) || (state_q == StError));
  end

  assign pc_we       = retire;
  assign instr_done  = retire;
  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: per-instruction expected stage traces built from opcode, memory delay
// and halt request, with randomized don't-care inputs outside the cycles where they matter.
module tb_stage_sequencer;

  localparam int unsigned MT   = 4;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  localparam int SI = 0, SF = 1, SD = 2, SE = 3, SM = 4, SW = 5, SH = 6, SX = 7;
  localparam logic [5:0] R = 6'h00, LW = 6'h23, SWOP = 6'h2B, BEQ = 6'h04, HLT = 6'h3F;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, halt_req = 1'b0, mem_ready = 1'b0;
  logic [5:0]    opcode = '0;
  logic          if_en, id_en, ex_en, mem_en, wb_en, mem_req, pc_we, instr_done, busy;
  logic          illegal_op, mem_timeout;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  int total = 0, bad = 0;
  int exp_cnt = 0;
  bit exp_ill = 0, exp_to = 0;

  stage_sequencer #(.CNT_W(CW), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .opcode(opcode),
    .mem_ready(mem_ready), .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en),
    .wb_en(wb_en), .mem_req(mem_req), .pc_we(pc_we), .instr_done(instr_done), .busy(busy),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] act();
    return {if_en, id_en, ex_en, mem_en, wb_en, mem_req, pc_we, instr_done, busy};
  endfunction

  // Output vector a given stage should show; ret marks the retirement cycle.
  function automatic logic [8:0] exp_outs(input int s, input bit ret);
    return {s == SF, s == SD, s == SE, s == SM, s == SW, s == SM, ret, ret, (s >= SF && s <= SW)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, state, SI);
    chk({tag, "_outs"}, act(), 0);
    chk({tag, "_cnt"}, instr_count, 0);
    chk({tag, "_flags"}, {illegal_op, mem_timeout}, 0);
    exp_cnt = 0;
    exp_ill = 0;
    exp_to  = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_reset_vals("rst");
    tick();
    reset = 1'b1;
  endtask

  // From IDLE: one idle cycle with start low, then start high into FETCH.
  task automatic go();
    start = 1'b0;
    mem_ready = 1'($urandom);
    #3;
    chk("idle_hold", state, SI);
    tick();
    start = 1'b1;
    halt_req = 1'($urandom);
    mem_ready = 1'($urandom);
    opcode = 6'($urandom);
    #3;
    chk("idle_state", state, SI);
    chk("idle_outs", act(), 0);
    tick();
  endtask

  // Expects the DUT in FETCH. d = number of not-ready MEMORY cycles before ready.
  // abort >= 0 pulses reset at that trace index instead of finishing the instruction.
  task automatic run_instr(input logic [5:0] op, input int d, input bit hreq, input int abort,
                           output int fin);
    int tr[$];
    int ret_idx = -1;
    int nm = 0;
    int m;
    bit legal;
    fin = -1;
    legal = (op == R) || (op == LW) || (op == SWOP) || (op == BEQ);
    tr.push_back(SF);
    tr.push_back(SD);
    if (op == HLT) fin = SH;
    else if (!legal) fin = SX;
    else begin
      tr.push_back(SE);
      if (op == R) tr.push_back(SW);
      else if (op != BEQ) begin
        m = (d < int'(MT)) ? d + 1 : int'(MT);
        repeat (m) tr.push_back(SM);
        if (d >= int'(MT)) fin = SX;
        else if (op == LW) tr.push_back(SW);
      end
      if (fin < 0) begin
        ret_idx = tr.size() - 1;
        fin = hreq ? SI : SF;
      end
    end

    foreach (tr[i]) begin
      int s;
      bit r;
      s = tr[i];
      r = (i == ret_idx);
      opcode    = (s == SD) ? op : 6'($urandom);
      mem_ready = (s == SM) ? (nm == d) : 1'($urandom);
      halt_req  = r ? hreq : 1'($urandom);
      start     = 1'($urandom);
      #3;
      chk($sformatf("state[%0d] op%0h", i, op), state, s);
      chk($sformatf("outs[%0d] op%0h", i, op), act(), exp_outs(s, r));
      if (s == SM) nm++;
      if (r && exp_cnt != CMAX) exp_cnt++;
      if (i == abort) begin
        reset = 1'b0;
        #1;
        check_reset_vals("abort");
        tick();
        reset = 1'b1;
        fin = SI;
        return;
      end
      tick();
    end

    if (fin == SX) begin
      if (!legal) exp_ill = 1;
      else exp_to = 1;
    end
    chk($sformatf("next op%0h", op), state, fin);
    chk("illegal_op", illegal_op, exp_ill);
    chk("mem_timeout", mem_timeout, exp_to);
    chk("count", instr_count, exp_cnt);
  endtask

  // Resume after an instruction: restart from IDLE, or verify absorption, reset and restart.
  task automatic settle(input int fin);
    if (fin == SI) go();
    else if (fin == SH || fin == SX) begin
      repeat (2) begin
        start = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'($urandom);
        #3;
        chk("absorb_state", state, fin);
        chk("absorb_outs", act(), 0);
        tick();
      end
      do_reset();
      go();
    end
  endtask

  task automatic instr(input logic [5:0] op, input int d, input bit hreq);
    int fin;
    run_instr(op, d, hreq, -1, fin);
    settle(fin);
  endtask

  initial begin
    int fin;
    #2;
    do_reset();
    go();
    // Directed scenarios
    instr(R, 0, 0);
    instr(LW, 3, 0);
    instr(SWOP, 0, 0);
    repeat (3) instr(BEQ, 0, 0);
    instr(LW, 9, 0);          // ready never comes: timeout
    instr(LW, MT - 1, 1);     // ready in the last allowed cycle, then halt to IDLE
    instr(6'h3E, 0, 0);       // illegal opcode
    instr(HLT, 0, 0);
    run_instr(LW, 5, 0, 4, fin);  // reset during the second MEMORY cycle
    go();
    repeat (CMAX + 2) instr(BEQ, 0, 0);  // counter saturation
    chk("sat_count", instr_count, CMAX);
    // Randomized instruction mix
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      int k;
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: op = R;
        3, 4:    op = LW;
        5, 6:    op = SWOP;
        7, 8:    op = BEQ;
        default: op = ($urandom_range(0, 1) == 0) ? HLT : 6'($urandom);
      endcase
      instr(op, $urandom_range(0, MT), ($urandom_range(0, 4) == 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
